uart_pkt_deframer: RTL



---
 rtl/uart_pkt_pkg.sv | 22 ++
 rtl/uart_pkt_deframer_fetch.sv | 38 +++
 rtl/uart_pkt_deframer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared types for the UART packet deframer.
// FSM states, frame error codes and the default start-of-frame marker.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHK,
    REPORT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_CHK,
    ERR_LEN,
    ERR_TIMEOUT
  } err_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pkt_deframer_fetch.sv
// uart_byte_fetch: one-byte-at-a-time read handshake on the UART RX FIFO.
// rd_uart pulses for one cycle; the byte is presented with byte_vld next cycle.
module uart_byte_fetch
  import uart_pkt_pkg::*;
#(
  parameter int DBIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  output logic            byte_vld,
  output logic [DBIT-1:0] rx_byte
);

  logic pend_q;
  logic pend_d;

  // No new read while a byte is in flight: at most one byte per 2 clk.
  assign rd_uart  = rst_n && req && !rx_empty && !pend_q;
  assign byte_vld = pend_q;
  assign rx_byte  = r_data;

  always_comb begin
    pend_d = rd_uart;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/uart_pkt_deframer.sv
// uart_pkt_deframer: parses SOF, LEN, payload[LEN], CHK from the UART RX FIFO.
// Optional inter-byte timeout is enabled by defining UART_PKT_TIMEOUT_EN.
module uart_pkt_deframer
  import uart_pkt_pkg::*;
#(
  parameter int              DBIT           = 8,
  parameter int              MAX_LEN        = 64,
  parameter logic [DBIT-1:0] SOF_BYTE       = DBIT'(SOF_DEFAULT),
  parameter int              TIMEOUT_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  output logic [DBIT-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic            frame_done,
  output logic            frame_ok,
  output logic [1:0]      err_code
);

  localparam logic [DBIT-1:0] MAX_B = DBIT'(MAX_LEN);
  localparam logic [DBIT-1:0] ONE_B = DBIT'(1);

  state_e          state_q, state_d;
  err_e            err_q, err_d;
  logic [DBIT-1:0] cnt_q, cnt_d;
  logic [DBIT-1:0] chk_q, chk_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            mv_q, mv_d;
  logic            fetch_req;
  logic            byte_vld;
  logic [DBIT-1:0] rx_byte;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  uart_byte_fetch #(
    .DBIT(DBIT)
  ) u_fetch (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (fetch_req),
    .rx_empty(rx_empty),
    .r_data  (r_data),
    .rd_uart (rd_uart),
    .byte_vld(byte_vld),
    .rx_byte (rx_byte)
  );

  assign m_data     = data_q;
  assign m_valid    = mv_q;
  assign m_last     = mv_q && (cnt_q == ONE_B);
  assign frame_done = (state_q == REPORT);
  assign frame_ok   = frame_done && (err_q == ERR_NONE);
  assign err_code   = err_q;

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    chk_d     = chk_q;
    data_d    = data_q;
    mv_d      = mv_q;
    fetch_req = 1'b0;
    unique case (state_q)
      HUNT: begin
        fetch_req = 1'b1;
        if (byte_vld && rx_byte == SOF_BYTE) begin
          state_d = LEN;
        end
      end
      LEN: begin
        fetch_req = 1'b1;
        if (byte_vld) begin
          if (rx_byte == '0 || rx_byte > MAX_B) begin
            err_d   = ERR_LEN;
            state_d = REPORT;
          end else begin
            cnt_d   = rx_byte;
            chk_d   = rx_byte;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        // The checksum byte is fetched from CHK, not behind the last payload byte.
        fetch_req = !mv_q || (m_ready && cnt_q != ONE_B);
        if (mv_q && m_ready) begin
          mv_d  = 1'b0;
          cnt_d = cnt_q - ONE_B;
          if (cnt_q == ONE_B) begin
            state_d = CHK;
          end
        end
        if (byte_vld) begin
          data_d = rx_byte;
          mv_d   = 1'b1;
          chk_d  = chk_q ^ rx_byte;
        end
      end
      CHK: begin
        fetch_req = 1'b1;
        if (byte_vld) begin
          err_d   = (rx_byte == chk_q) ? ERR_NONE : ERR_CHK;
          state_d = REPORT;
        end
      end
      REPORT: begin
        state_d = HUNT;
        err_d   = ERR_NONE;
        cnt_d   = '0;
        chk_d   = '0;
        data_d  = '0;
        mv_d    = 1'b0;
      end
      default: begin
        state_d = HUNT;
      end
    endcase
`ifdef UART_PKT_TIMEOUT_EN
    tmo_d = '0;
    if ((state_q inside {LEN, PAYLOAD, CHK}) && !rd_uart) begin
      tmo_d = tmo_q;
      if (fetch_req && rx_empty && !byte_vld) begin
        tmo_d = tmo_q + 1'b1;
      end
      if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
        state_d = REPORT;
        err_d   = ERR_TIMEOUT;
        mv_d    = 1'b0;
        tmo_d   = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
      chk_q   <= '0;
      data_q  <= '0;
      mv_q    <= 1'b0;
`ifdef UART_PKT_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      data_q  <= data_d;
      mv_q    <= mv_d;
`ifdef UART_PKT_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule
